mem_responder: RTL and testbench

- Memory-side responder for the multicycle RV32I core's data/instruction memory port. It is the slave end of the interface that the datapath and control drive: word address, write data, 4-bit byte mask, and read/write strobes.
- Accepts one request at a time and completes it after a fixed, parameterised latency with a single-cycle mem_resp.
- Backed by an internal word array. Used as the memory behind the core in block-level simulation and as the stand-in for the two-way cache's lower level.

---
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Memory port bundle between the core's datapath/control (master) and
// the memory responder (slave): word-aligned address, lane-positioned
// write data, byte mask, read/write strobes, read data and completion.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_rdata,
    output mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder backed by a word array. One request is
// in flight at a time; it completes LATENCY cycles after acceptance with
// a single-cycle mem_resp. Writes merge enabled byte lanes into the word
// at the closing edge of the response cycle; reads present the word
// during the response cycle and hold it until the next read response.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus,
  output logic             err,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
);

  localparam int IW = $clog2(DEPTH_WORDS);
  // Counter only has to hold LATENCY-2 (the extra WAIT cycles).
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Saturating increment for the completion counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Replace only the byte lanes selected by the mask.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_op_q, wr_op_d;
  logic            resp_q, resp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;

  logic [IW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;

  logic            req;
  logic [IW-1:0]   req_idx;
  logic [IW-1:0]   rd_idx;
  logic            mem_we;
  logic            unused_addr_bits;

  assign req     = bus.mem_read | bus.mem_write;
  assign req_idx = bus.mem_address[IW+1:2];
  // Upper address bits wrap; low two bits are aligned by the initiator.
  assign unused_addr_bits = ^{bus.mem_address[31:IW+2], bus.mem_address[1:0]};

  // Next-state, request latching, counters and registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_op_d  = wr_op_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rdata_d  = rdata_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rd_idx   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          rd_idx  = req_idx;
          wr_op_d = bus.mem_write;
          wdata_d = bus.mem_wdata;
          be_d    = bus.mem_byte_enable;
          if (bus.mem_read && bus.mem_write) err_d = 1'b1;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (wr_op_q) wr_cnt_d = sat_inc(wr_cnt_q);
        else         rd_cnt_d = sat_inc(rd_cnt_q);
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered: prepare them for the cycle we enter next.
    resp_d = (state_d == S_RESP);
    if (state_d == S_RESP && !wr_op_d) rdata_d = mem_q[rd_idx];
  end

  // FSM state and control/output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_op_q  <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_op_q  <= wr_op_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Latched request payload; only meaningful while a request is in flight.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  // A write lands at the closing edge of its response cycle. Reset forces
  // the FSM out of RESP, so an aborted request never reaches the array.
  assign mem_we = (state_q == S_RESP) && wr_op_q;

  // Word array update with byte-lane merge.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= merge_bytes(mem_q[idx_q], wdata_q, be_q);
  end

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;
  assign err           = err_q;
  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance A (LATENCY=2) is tracked every cycle
// by a transaction-level model; instance B (LATENCY=1) covers
// back-to-back and early-drop timing with directed expectations.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus_a ();
  mem_responder_if bus_b ();

  logic        err_a, err_b;
  logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .err(err_a), .rd_count(rdc_a), .wr_count(wrc_a)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .err(err_b), .rd_count(rdc_b), .wr_count(wrc_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model of instance A ----------------
  logic [31:0] mm [DEPTH];
  int          cyc = 0;
  int          ended;
  bit          m_busy;
  int          m_resp_at;
  bit          m_wr;
  int          m_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_be;
  logic        e_resp;
  logic [31:0] e_rdata;
  logic        e_err;
  logic [15:0] e_rd, e_wr;

  initial begin
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    m_busy = 0; m_resp_at = -1;
    e_resp = 0; e_rdata = '0; e_err = 0; e_rd = '0; e_wr = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_busy = 0; e_resp = 0; e_rdata = '0; e_err = 0; e_rd = '0; e_wr = '0;
      end else begin
        ended = cyc;
        cyc   = cyc + 1;
        if (m_busy && ended == m_resp_at) begin
          if (m_wr) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) mm[m_idx][8*b +: 8] = m_wd[8*b +: 8];
            if (e_wr != 16'hFFFF) e_wr = e_wr + 16'd1;
          end else begin
            if (e_rd != 16'hFFFF) e_rd = e_rd + 16'd1;
          end
          m_busy = 0;
        end else if (!m_busy && (bus_a.mem_read || bus_a.mem_write)) begin
          m_busy    = 1;
          m_resp_at = ended + LAT_A;
          m_wr      = bus_a.mem_write;
          m_idx     = int'((bus_a.mem_address >> 2) % DEPTH);
          m_wd      = bus_a.mem_wdata;
          m_be      = bus_a.mem_byte_enable;
          if (bus_a.mem_read && bus_a.mem_write) e_err = 1;
        end
        e_resp = m_busy && (cyc == m_resp_at);
        if (e_resp && !m_wr) e_rdata = mm[m_idx];
      end
    end
  end

  // ---------------- per-cycle compare of instance A ----------------
  bit chk_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("a_resp",     {31'b0, bus_a.mem_resp}, {31'b0, e_resp});
        check("a_rdata",    bus_a.mem_rdata, e_rdata);
        check("a_err",      {31'b0, err_a}, {31'b0, e_err});
        check("a_rd_count", {16'b0, rdc_a}, {16'b0, e_rd});
        check("a_wr_count", {16'b0, wrc_a}, {16'b0, e_wr});
      end
    end
  end

  // Issue one request on A; waits (bounded) for its response.
  task automatic req_a(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input bit early,
                       output logic [31:0] rdata, output int lat);
    int t0;
    bit got;
    got = 0; rdata = '0; lat = -1;
    @(negedge clk);
    bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.mem_address = addr;
    bus_a.mem_wdata = wd; bus_a.mem_byte_enable = be;
    t0 = cyc;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (early && i == 0) begin
        bus_a.mem_read = 0; bus_a.mem_write = 0;
        bus_a.mem_address = '0; bus_a.mem_wdata = '0; bus_a.mem_byte_enable = '0;
      end
      if (bus_a.mem_resp) begin
        got = 1; rdata = bus_a.mem_rdata; lat = cyc - t0;
      end
    end
    bus_a.mem_read = 0; bus_a.mem_write = 0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL a_timeout addr=%h actual=no_resp expected=resp_within_20", addr);
    end
  endtask

  logic [31:0] rd_v;
  int          lat;
  int          pulses;
  bit          got_b;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus_a.mem_read = 0; bus_a.mem_write = 0; bus_a.mem_address = '0;
    bus_a.mem_wdata = '0; bus_a.mem_byte_enable = '0;
    bus_b.mem_read = 0; bus_b.mem_write = 0; bus_b.mem_address = '0;
    bus_b.mem_wdata = '0; bus_b.mem_byte_enable = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    #2 rst = 1'b1;

    // Reset then idle.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_a.mem_resp) pulses++;
    end
    check("idle_resp_pulses", pulses, 0);
    check("idle_rdata", bus_a.mem_rdata, 32'h0);
    check("idle_counts", {rdc_a, wrc_a}, 32'h0);

    // Full-word write/read.
    req_a(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd_v, lat);
    check("wr_latency", lat, 2);
    req_a(1, 0, 32'h10, 32'h0, 4'h0, 0, rd_v, lat);
    check("rd_latency", lat, 2);
    check("rd_deadbeef", rd_v, 32'hDEADBEEF);
    @(negedge clk);
    check("counts_after_first", {rdc_a, wrc_a}, {16'd1, 16'd1});

    // Byte and half masks.
    req_a(0, 1, 32'h20, 32'h11223344, 4'hF, 0, rd_v, lat);
    req_a(0, 1, 32'h20, 32'h0000AA00, 4'b0010, 0, rd_v, lat);
    req_a(0, 1, 32'h20, 32'hBBBB0000, 4'b1100, 0, rd_v, lat);
    req_a(1, 0, 32'h20, 32'h0, 4'h0, 0, rd_v, lat);
    check("rd_masked", rd_v, 32'hBBBBAA44);
    req_a(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd_v, lat);
    check("zero_mask_latency", lat, 2);
    req_a(1, 0, 32'h20, 32'h0, 4'h0, 0, rd_v, lat);
    check("rd_after_zero_mask", rd_v, 32'hBBBBAA44);
    @(negedge clk);
    check("wr_count_masks", {16'b0, wrc_a}, 32'd5);

    // Address wrap and read/write conflict.
    req_a(0, 1, 32'h404, 32'h12345678, 4'hF, 0, rd_v, lat);
    req_a(1, 0, 32'h004, 32'h0, 4'h0, 0, rd_v, lat);
    check("rd_wrap", rd_v, 32'h12345678);
    req_a(1, 1, 32'h008, 32'h0BADF00D, 4'hF, 0, rd_v, lat);
    check("conflict_err", {31'b0, err_a}, 32'd1);
    req_a(1, 0, 32'h008, 32'h0, 4'h0, 0, rd_v, lat);
    check("conflict_as_write", rd_v, 32'h0BADF00D);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'b0, err_a}, 32'd1);

    // Early strobe drop on A.
    req_a(0, 1, 32'h0C, 32'h55AA55AA, 4'hF, 1, rd_v, lat);
    check("early_drop_latency", lat, 2);
    req_a(1, 0, 32'h0C, 32'h0, 4'h0, 1, rd_v, lat);
    check("early_drop_data", rd_v, 32'h55AA55AA);

    // LATENCY=1 instance: seed word 0, then continuous reads.
    @(negedge clk);
    bus_b.mem_write = 1; bus_b.mem_address = 32'h0;
    bus_b.mem_wdata = 32'hCAFEF00D; bus_b.mem_byte_enable = 4'hF;
    got_b = 0;
    for (int i = 0; i < 10 && !got_b; i++) begin
      @(negedge clk);
      if (bus_b.mem_resp) got_b = 1;
    end
    bus_b.mem_write = 0;
    check("b_seed_resp", {31'b0, got_b}, 32'd1);
    @(negedge clk);
    bus_b.mem_read = 1; bus_b.mem_address = 32'h0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("b2b_resp_pattern", {31'b0, bus_b.mem_resp}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (bus_b.mem_resp) check("b2b_rdata", bus_b.mem_rdata, 32'hCAFEF00D);
    end
    bus_b.mem_read = 0;
    @(negedge clk);
    check("b2b_rd_count", {16'b0, rdc_b}, 32'd6);
    check("b2b_wr_count", {16'b0, wrc_b}, 32'd1);

    // Early drop on B: strobe high for exactly one cycle.
    bus_b.mem_write = 1; bus_b.mem_address = 32'h4;
    bus_b.mem_wdata = 32'h01020304; bus_b.mem_byte_enable = 4'hF;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) bus_b.mem_write = 0;
      if (bus_b.mem_resp) pulses++;
    end
    check("b_early_drop_pulses", pulses, 1);
    check("b_early_drop_count", {16'b0, wrc_b}, 32'd2);

    // Reset in the middle of a request.
    req_a(0, 1, 32'h30, 32'h00000000, 4'hF, 0, rd_v, lat);
    @(negedge clk);
    bus_a.mem_write = 1; bus_a.mem_address = 32'h30;
    bus_a.mem_wdata = 32'hFFFFFFFF; bus_a.mem_byte_enable = 4'hF;
    @(negedge clk);
    #2 rst = 1'b0;
    bus_a.mem_write = 0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus_a.mem_resp) pulses++;
    end
    #2 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.mem_resp) pulses++;
    end
    check("midreset_no_resp", pulses, 0);
    check("midreset_counts", {rdc_a, wrc_a}, 32'h0);
    check("midreset_err", {31'b0, err_a}, 32'd0);
    check("midreset_rdata", bus_a.mem_rdata, 32'h0);
    req_a(1, 0, 32'h30, 32'h0, 4'h0, 0, rd_v, lat);
    check("midreset_word_unchanged", rd_v, 32'h00000000);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
